// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_pkg
//  Description : Shared mode encodings, flag bit positions, FSM state type and
//                a small overflow helper for the alu_pipe block.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pipe_pkg;

    // Operation select encodings
    localparam logic [3:0] MODE_ADD   = 4'b0000;
    localparam logic [3:0] MODE_SUB   = 4'b0001;
    localparam logic [3:0] MODE_AND   = 4'b0010;
    localparam logic [3:0] MODE_OR    = 4'b0011;
    localparam logic [3:0] MODE_XOR   = 4'b0100;
    localparam logic [3:0] MODE_NOT   = 4'b0101;
    localparam logic [3:0] MODE_SLL   = 4'b0110;
    localparam logic [3:0] MODE_SLL2  = 4'b0111;
    localparam logic [3:0] MODE_SRA   = 4'b1000;
    localparam logic [3:0] MODE_SRL   = 4'b1001;
    localparam logic [3:0] MODE_ADDSH = 4'b1010;
    localparam logic [3:0] MODE_MUL   = 4'b1011;
    localparam logic [3:0] MODE_SLT   = 4'b1100;
    localparam logic [3:0] MODE_SLTU  = 4'b1101;

    // Bit positions inside the 5-bit flags word {ILL, V, C, N, Z}
    localparam int FLAG_Z   = 0;
    localparam int FLAG_N   = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_ILL = 4;
    localparam int FLAG_W   = 5;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_MUL  = 2'd2
    } state_t;

    // Two's complement overflow of an addition given the operand and sum signs
    function automatic logic add_overflow(input logic sign_a,
                                          input logic sign_b,
                                          input logic sign_r);
        return (sign_a == sign_b) && (sign_r != sign_a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipe_mul.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe_mul
//  Description : Iterative shift-add multiplier, one partial product per
//                cycle, WIDTH iterations. done is asserted during the final
//                iteration and product already includes that iteration.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc_next;

    // Partial-product accumulate for the current iteration
    always_comb begin
        acc_next = acc;
        if (multiplier[0]) begin
            acc_next = acc + multiplicand;
        end
    end

    assign busy    = (count != '0);
    assign done    = (count == CW'(1));
    assign product = acc_next;

    // Operand load on start, then shift/accumulate until count drains
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            multiplicand <= '0;
            multiplier   <= '0;
            acc          <= '0;
            count        <= '0;
        end else if (start) begin
            multiplicand <= a;
            multiplier   <= b;
            acc          <= '0;
            count        <= CW'(WIDTH);
        end else if (busy) begin
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
            acc          <= acc_next;
            count        <= count - CW'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pipe
//  Description : Registered ALU with valid/ready on input and output. Single
//                cycle ops are computed combinationally and captured on the
//                accept edge; multiply runs in alu_pipe_mul for WIDTH cycles.
//                Build macro ALU_PIPE_MUL_EN enables the multiplier; without
//                it mode 1011 is reported as illegal.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [3:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    state_t state;
    state_t state_next;

    logic              accept;
    logic              is_mul;
    logic              mul_done;
    logic              mul_busy;
    logic [WIDTH-1:0]  mul_product;
    logic [FLAG_W-1:0] mul_flags;

    logic [WIDTH:0]    add_sum;
    logic [WIDTH:0]    sub_diff;
    logic [WIDTH:0]    addsh_sum;
    logic [WIDTH-1:0]  b_sh2;
    logic [SHW-1:0]    shamt;

    logic [WIDTH-1:0]  alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              alu_ill;
    logic [FLAG_W-1:0] alu_flags;

    assign accept = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    assign is_mul = (mode == MODE_MUL);

    alu_pipe_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (accept && is_mul),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul      = 1'b0;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // Multiply result only ever reports Z and N
    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_product == '0);
        mul_flags[FLAG_N] = mul_product[WIDTH-1];
    end

    // Shared adders: subtract is a + ~b + 1 so the carry-out means "no borrow"
    assign b_sh2     = {op_b[WIDTH-3:0], 2'b00};
    assign shamt     = op_b[SHW-1:0];
    assign add_sum   = {1'b0, op_a} + {1'b0, op_b};
    assign sub_diff  = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
    assign addsh_sum = {1'b0, op_a} + {1'b0, b_sh2};

    // Single-cycle operation select with carry/overflow
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (mode)
            MODE_ADD: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = add_overflow(op_a[WIDTH-1], op_b[WIDTH-1], add_sum[WIDTH-1]);
            end
            MODE_SUB: begin
                alu_res = sub_diff[WIDTH-1:0];
                alu_c   = sub_diff[WIDTH];
                alu_v   = add_overflow(op_a[WIDTH-1], ~op_b[WIDTH-1], sub_diff[WIDTH-1]);
            end
            MODE_AND:  alu_res = op_a & op_b;
            MODE_OR:   alu_res = op_a | op_b;
            MODE_XOR:  alu_res = op_a ^ op_b;
            MODE_NOT:  alu_res = ~op_a;
            MODE_SLL,
            MODE_SLL2: alu_res = op_a << shamt;
            MODE_SRA:  alu_res = $unsigned($signed(op_a) >>> shamt);
            MODE_SRL:  alu_res = op_a >> shamt;
            MODE_ADDSH: begin
                alu_res = addsh_sum[WIDTH-1:0];
                alu_c   = addsh_sum[WIDTH];
                alu_v   = add_overflow(op_a[WIDTH-1], b_sh2[WIDTH-1], addsh_sum[WIDTH-1]);
            end
`ifdef ALU_PIPE_MUL_EN
            // Result comes from the multiplier engine, not this path
            MODE_MUL:  alu_res = '0;
`endif
            MODE_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            MODE_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            default:   alu_ill = 1'b1;
        endcase
    end

    // Flag assembly; an illegal op reports only ILL
    always_comb begin
        alu_flags           = '0;
        alu_flags[FLAG_ILL] = alu_ill;
        if (!alu_ill) begin
            alu_flags[FLAG_Z] = (alu_res == '0);
            alu_flags[FLAG_N] = alu_res[WIDTH-1];
            alu_flags[FLAG_C] = alu_c;
            alu_flags[FLAG_V] = alu_v;
        end
    end

    // Handshake outputs decoded from state (never from in_valid)
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Next-state: accept wins over drain in HOLD, giving back-to-back issue
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    state_next = is_mul ? ST_MUL : ST_HOLD;
                end else if ((state == ST_HOLD) && out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_next = ST_HOLD;
                end else if (!mul_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Output register: loaded on single-cycle accept or multiply completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            flags  <= '0;
        end else if (accept && !is_mul) begin
            result <= alu_res;
            flags  <= alu_flags;
        end else if ((state == ST_MUL) && mul_done) begin
            result <= mul_product;
            flags  <= mul_flags;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_pipe
//  Description : Self-checking bench for alu_pipe (WIDTH = 32) with a
//                scoreboard of expected {flags, result} words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pipe;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [3:0]   mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [4:0]   flags;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [36:0] sb_q[$];
    int          pop_cyc[$];
    logic [36:0] mon_exp;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: returns {ILL, V, C, N, Z, result}
    function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] m);
        logic [31:0] r;
        logic [31:0] bb;
        logic [63:0] u;
        logic        c;
        logic        v;
        logic        ill;
        longint      sa;
        longint      sb;
        longint      s;
        int          sh;
        r   = '0;
        c   = 1'b0;
        v   = 1'b0;
        ill = 1'b0;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        sh  = int'(b[4:0]);
        case (m)
            4'd0: begin
                u = {32'b0, a} + {32'b0, b};
                r = u[31:0]; c = u[32];
                s = sa + sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                r = a - b; c = (a >= b);
                s = sa - sb;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6, 4'd7: r = a << sh;
            4'd8: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            4'd9: r = a >> sh;
            4'd10: begin
                bb = {b[29:0], 2'b00};
                u = {32'b0, a} + {32'b0, bb};
                r = u[31:0]; c = u[32];
                s = sa + longint'($signed(bb));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
`ifdef ALU_PIPE_MUL_EN
            4'd11: begin
                u = {32'b0, a} * {32'b0, b};
                r = u[31:0];
            end
`endif
            4'd12: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd13: r = (a < b) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
        if (ill) return {5'b10000, 32'h0};
        return {1'b0, v, c, r[31], (r == 32'h0), r};
    endfunction

    // Scoreboard: each transferred output is checked against the queue head
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got flags=%b result=%h, required no output", flags, result);
            end else begin
                mon_exp = sb_q.pop_front();
                if ({flags, result} !== mon_exp) begin
                    n_bad++;
                    $display("FAIL sb_result: got flags=%b result=%h, required flags=%b result=%h",
                             flags, result, mon_exp[36:32], mon_exp[31:0]);
                end
            end
            pop_cyc.push_back(cyc);
        end
    end

    // Present one op, wait (bounded) for in_ready, push expectation on accept
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] m);
        int wait_n;
        wait_n   = 0;
        op_a     = a;
        op_b     = b;
        mode     = m;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && wait_n < 100) begin
            @(negedge clk);
            wait_n++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        sb_q.push_back(model(a, b, m));
        #1;
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        mode     = 4'($urandom);
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL rst_result: got %h, required 0", result); end
        n_cmp++; if (flags !== 5'b0) begin n_bad++; $display("FAIL rst_flags: got %b, required 0", flags); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add_overflow();
        out_ready = 1'b1;
        issue(32'h7FFF_FFFF, 32'h0000_0001, 4'b0000);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL add_latency: out_valid=%b, required 1", out_valid); end
        n_cmp++; if (result !== 32'h8000_0000) begin n_bad++; $display("FAIL add_result: got %h, required 80000000", result); end
        n_cmp++; if (flags !== 5'b01010) begin n_bad++; $display("FAIL add_flags: got %b, required 01010", flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_zero();
        issue(32'd5, 32'd5, 4'b0001);
        @(negedge clk);
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL sub_result: got %h, required 0", result); end
        n_cmp++; if (flags !== 5'b00101) begin n_bad++; $display("FAIL sub_flags: got %b, required 00101", flags); end
        @(posedge clk); #1;
    endtask

    task automatic test_shifts_and_ops();
        issue(32'h8000_0000, 32'h0000_0024, 4'b1000);
        @(negedge clk);
        n_cmp++; if (result !== 32'hF800_0000) begin n_bad++; $display("FAIL sra_result: got %h, required f8000000", result); end
        @(posedge clk); #1;
        issue(32'h8000_0000, 32'h0000_0024, 4'b1001);
        @(negedge clk);
        n_cmp++; if (result !== 32'h0800_0000) begin n_bad++; $display("FAIL srl_result: got %h, required 08000000", result); end
        @(posedge clk); #1;
        issue(32'hFFFF_FFFF, 32'd1, 4'b1100);
        issue(32'hFFFF_FFFF, 32'd1, 4'b1101);
        issue(32'hC000_0001, 32'hFFFF_FFFF, 4'b1010);
        for (int m = 0; m < 14; m++) begin
            if (m != 11) begin
                for (int k = 0; k < 3; k++) begin
                    issue($urandom, $urandom, 4'(m));
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        int n;
        int ir_bad;
        logic [31:0] exp_r;
        logic [4:0]  exp_f;
        int          exp_lat;
`ifdef ALU_PIPE_MUL_EN
        exp_r = 32'hFFFF_FFEB; exp_f = 5'b00010; exp_lat = 32;
`else
        exp_r = 32'h0; exp_f = 5'b10000; exp_lat = 0;
`endif
        out_ready = 1'b1;
        n = 0;
        ir_bad = 0;
        issue(32'd7, 32'hFFFF_FFFD, 4'b1011);
        @(negedge clk);
        while (!out_valid && n < 64) begin
            if (in_ready) ir_bad++;
            n++;
            @(negedge clk);
        end
        n_cmp++; if (n != exp_lat) begin n_bad++; $display("FAIL mul_latency: got %0d, required %0d", n, exp_lat); end
        n_cmp++; if (ir_bad != 0) begin n_bad++; $display("FAIL mul_in_ready: high on %0d cycles, required 0", ir_bad); end
        n_cmp++; if (result !== exp_r) begin n_bad++; $display("FAIL mul_result: got %h, required %h", result, exp_r); end
        n_cmp++; if (flags !== exp_f) begin n_bad++; $display("FAIL mul_flags: got %b, required %b", flags, exp_f); end
        @(posedge clk); #1;
        issue($urandom, $urandom, 4'b1011);
        issue(32'h0001_0000, 32'h0001_0000, 4'b1011);
        repeat (40) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        issue(32'h1234_5678, 32'h1111_1111, 4'b0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {flags, result} !== {5'b00000, 32'h2345_6789}) begin
                n_bad++;
                $display("FAIL bp_hold: out_valid=%b in_ready=%b flags=%b result=%h, required 1 0 00000 23456789",
                         out_valid, in_ready, flags, result);
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        pop_cyc.delete();
        issue(32'd1, 32'd2, 4'b0000);
        issue(32'hFFFF_FFFF, 32'd1, 4'b0000);
        issue(32'h8000_0000, 32'h8000_0000, 4'b0000);
        issue(32'hDEAD_0000, 32'h0000_BEEF, 4'b0000);
        @(negedge clk); #1;
        n_cmp++;
        if (pop_cyc.size() != 5 || pop_cyc[4] - pop_cyc[0] != 4) begin
            n_bad++;
            $display("FAIL b2b_throughput: %0d outputs, span %0d cycles, required 5 outputs over 4 cycles",
                     pop_cyc.size(), (pop_cyc.size() == 5) ? pop_cyc[4] - pop_cyc[0] : -1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int vcount;
        vcount = 0;
`ifdef ALU_PIPE_MUL_EN
        out_ready = 1'b1;
        issue(32'd7, 32'hFFFF_FFFD, 4'b1011);
        repeat (9) @(posedge clk);
`else
        out_ready = 1'b0;
        issue(32'd3, 32'd4, 4'b0000);
        @(posedge clk);
`endif
        #2 rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid: got %b, required 0", out_valid); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL rstmid_result: got %h, required 0", result); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready); end
        repeat (40) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        n_cmp++; if (vcount != 0) begin n_bad++; $display("FAIL rstmid_pulse: out_valid high %0d cycles, required 0", vcount); end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        issue(32'hDEAD_BEEF, 32'hCAFE_F00D, 4'b1110);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ill_latency: out_valid=%b, required 1", out_valid); end
        n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL ill_result: got %h, required 0", result); end
        n_cmp++; if (flags !== 5'b10000) begin n_bad++; $display("FAIL ill_flags: got %b, required 10000", flags); end
        @(posedge clk); #1;
        issue(32'h1, 32'h2, 4'b1111);
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (sb_q.size() != 0) begin n_bad++; $display("FAIL sb_drain: %0d results outstanding, required 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_shifts_and_ops();
        test_mul();
        test_back_to_back();
        test_reset_mid_op();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
